// File: rtl/icw_init_sequencer.sv
// icw_init_sequencer: 8259A ICW1..ICW4 init sequence decode,
// init field registers, role/pin resolution and OCW strobes.
module icw_init_sequencer #(
    parameter int CASCADE_LINES = 8,
    parameter int ID_WIDTH      = 3,
    parameter bit DEFAULT_UPM   = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write_strobe,
    input  logic                     address_a0,
    input  logic [7:0]               internal_data_bus,
    input  logic                     sp_en_n_in,
    input  logic                     drive_data_bus,
    output logic                     init_done,
    output logic                     level_or_edge_config,
    output logic                     call_address_interval_4,
    output logic                     single_mode,
    output logic [10:0]              vector_address,
    output logic [CASCADE_LINES-1:0] cascade_config,
    output logic [ID_WIDTH-1:0]      cascade_id,
    output logic                     special_fully_nest_config,
    output logic                     buffered_mode_config,
    output logic                     buffered_master_or_slave_config,
    output logic                     auto_eoi_config,
    output logic                     u8086_or_mcs80_config,
    output logic                     slave_mode,
    output logic                     en_n_out,
    output logic                     en_oe,
    output logic                     write_ocw1,
    output logic                     write_ocw2,
    output logic                     write_ocw3
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    state_t state;
    state_t state_next;

    logic ic4;
    logic is_icw1;
    logic is_ocw2;
    logic is_ocw3;
    logic load_icw2;
    logic load_icw3;
    logic load_icw4;
    logic upm_default;
    logic ocw1_next;
    logic ocw2_next;
    logic ocw3_next;

    assign is_icw1 = !address_a0 && internal_data_bus[4];
    assign is_ocw2 = !address_a0 &&
                     (internal_data_bus[4:3] == 2'b00);
    assign is_ocw3 = !address_a0 &&
                     (internal_data_bus[4:3] == 2'b01);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (write_strobe) begin
            unique case (1'b1)
                is_icw1: state_next = WAIT_ICW2;
                load_icw2: begin
                    if (!single_mode) begin
                        state_next = WAIT_ICW3;
                    end else if (ic4) begin
                        state_next = WAIT_ICW4;
                    end else begin
                        state_next = READY;
                    end
                end
                load_icw3: state_next = ic4 ? WAIT_ICW4 : READY;
                load_icw4: state_next = READY;
                default: ;
            endcase
        end
    end

    // ICW1 always wins, so it masks every per-state load and strobe
    always_comb begin
        load_icw2 = 1'b0;
        load_icw3 = 1'b0;
        load_icw4 = 1'b0;
        ocw1_next = 1'b0;
        ocw2_next = 1'b0;
        ocw3_next = 1'b0;
        if (write_strobe && !is_icw1) begin
            unique case (state)
                WAIT_ICW2: load_icw2 = address_a0;
                WAIT_ICW3: load_icw3 = address_a0;
                WAIT_ICW4: load_icw4 = address_a0;
                READY: begin
                    ocw1_next = address_a0;
                    ocw2_next = is_ocw2;
                    ocw3_next = is_ocw3;
                end
                default: ;
            endcase
        end
    end

    assign upm_default = !ic4 &&
                         (load_icw3 || (load_icw2 && single_mode));
    assign init_done = (state == READY);

    always_ff @(posedge clock) begin
        if (reset) begin
            level_or_edge_config            <= 1'b0;
            call_address_interval_4         <= 1'b0;
            single_mode                     <= 1'b0;
            ic4                             <= 1'b0;
            vector_address                  <= '0;
            cascade_config                  <= '0;
            cascade_id                      <= '0;
            special_fully_nest_config       <= 1'b0;
            buffered_mode_config            <= 1'b0;
            buffered_master_or_slave_config <= 1'b0;
            auto_eoi_config                 <= 1'b0;
            u8086_or_mcs80_config           <= 1'b0;
        end else if (write_strobe && is_icw1) begin
            level_or_edge_config            <= internal_data_bus[3];
            call_address_interval_4         <= internal_data_bus[2];
            single_mode                     <= internal_data_bus[1];
            ic4                             <= internal_data_bus[0];
            vector_address[2:0]             <= internal_data_bus[7:5];
            cascade_config                  <= '0;
            cascade_id                      <= '0;
            special_fully_nest_config       <= 1'b0;
            buffered_mode_config            <= 1'b0;
            buffered_master_or_slave_config <= 1'b0;
            auto_eoi_config                 <= 1'b0;
            u8086_or_mcs80_config           <= 1'b0;
        end else begin
            if (load_icw2) begin
                vector_address[10:3] <= internal_data_bus;
            end
            if (load_icw3) begin
                cascade_config <= internal_data_bus[CASCADE_LINES-1:0];
                cascade_id     <= internal_data_bus[ID_WIDTH-1:0];
            end
            if (load_icw4) begin
                special_fully_nest_config       <= internal_data_bus[4];
                buffered_mode_config            <= internal_data_bus[3];
                buffered_master_or_slave_config <= internal_data_bus[2];
                auto_eoi_config                 <= internal_data_bus[1];
                u8086_or_mcs80_config           <= internal_data_bus[0];
            end
            if (upm_default) begin
                u8086_or_mcs80_config <= DEFAULT_UPM;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            write_ocw1 <= 1'b0;
            write_ocw2 <= 1'b0;
            write_ocw3 <= 1'b0;
        end else begin
            write_ocw1 <= ocw1_next;
            write_ocw2 <= ocw2_next;
            write_ocw3 <= ocw3_next;
        end
    end

    // buffered mode: role from ICW4, pin becomes the buffer enable
    always_comb begin
        if (single_mode) begin
            slave_mode = 1'b0;
        end else if (buffered_mode_config) begin
            slave_mode = ~buffered_master_or_slave_config;
        end else begin
            slave_mode = ~sp_en_n_in;
        end
    end

    assign en_oe    = buffered_mode_config;
    assign en_n_out = buffered_mode_config ? ~drive_data_bus : 1'b1;

endmodule

// File: tb/tb_icw_init_sequencer.sv
// tb_icw_init_sequencer: directed init sequences plus random writes
// checked against a queue-based model of the ICW sequence.
module tb_icw_init_sequencer;

    localparam bit UPM_DEF = 1'b1;

    logic        clock = 1'b0;
    logic        reset;
    logic        write_strobe;
    logic        address_a0;
    logic [7:0]  internal_data_bus;
    logic        sp_en_n_in;
    logic        drive_data_bus;
    logic        init_done;
    logic        level_or_edge_config;
    logic        call_address_interval_4;
    logic        single_mode;
    logic [10:0] vector_address;
    logic [7:0]  cascade_config;
    logic [2:0]  cascade_id;
    logic        special_fully_nest_config;
    logic        buffered_mode_config;
    logic        buffered_master_or_slave_config;
    logic        auto_eoi_config;
    logic        u8086_or_mcs80_config;
    logic        slave_mode;
    logic        en_n_out;
    logic        en_oe;
    logic        write_ocw1;
    logic        write_ocw2;
    logic        write_ocw3;

    int tests  = 0;
    int errors = 0;

    logic sp_lvl = 1'b1;
    logic dd_lvl = 1'b0;

    // model: remaining ICWs queued at ICW1 time
    int          pending[$];
    logic        m_ready, m_ltim, m_adi, m_sngl, m_ic4;
    logic [10:0] m_vec;
    logic [7:0]  m_cas;
    logic [2:0]  m_id;
    logic [4:0]  m_icw4;
    logic        m_o1, m_o2, m_o3;

    always #5 clock = ~clock;

    icw_init_sequencer #(
        .CASCADE_LINES(8),
        .ID_WIDTH(3),
        .DEFAULT_UPM(UPM_DEF)
    ) dut (
        .clock(clock),
        .reset(reset),
        .write_strobe(write_strobe),
        .address_a0(address_a0),
        .internal_data_bus(internal_data_bus),
        .sp_en_n_in(sp_en_n_in),
        .drive_data_bus(drive_data_bus),
        .init_done(init_done),
        .level_or_edge_config(level_or_edge_config),
        .call_address_interval_4(call_address_interval_4),
        .single_mode(single_mode),
        .vector_address(vector_address),
        .cascade_config(cascade_config),
        .cascade_id(cascade_id),
        .special_fully_nest_config(special_fully_nest_config),
        .buffered_mode_config(buffered_mode_config),
        .buffered_master_or_slave_config(buffered_master_or_slave_config),
        .auto_eoi_config(auto_eoi_config),
        .u8086_or_mcs80_config(u8086_or_mcs80_config),
        .slave_mode(slave_mode),
        .en_n_out(en_n_out),
        .en_oe(en_oe),
        .write_ocw1(write_ocw1),
        .write_ocw2(write_ocw2),
        .write_ocw3(write_ocw3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic ws,
                         input logic a0, input logic [7:0] d);
        int k;
        m_o1 = 1'b0;
        m_o2 = 1'b0;
        m_o3 = 1'b0;
        if (r) begin
            pending.delete();
            m_ready = 0; m_ltim = 0; m_adi = 0; m_sngl = 0; m_ic4 = 0;
            m_vec = '0; m_cas = '0; m_id = '0; m_icw4 = '0;
        end else if (ws) begin
            if (!a0 && d[4]) begin
                m_ltim = d[3]; m_adi = d[2]; m_sngl = d[1]; m_ic4 = d[0];
                m_vec[2:0] = d[7:5];
                m_cas = '0; m_id = '0; m_icw4 = '0; m_ready = 0;
                pending.delete();
                pending.push_back(2);
                if (!d[1]) pending.push_back(3);
                if (d[0]) pending.push_back(4);
            end else if (a0) begin
                if (pending.size() != 0) begin
                    k = pending.pop_front();
                    if (k == 2) begin
                        m_vec[10:3] = d;
                    end else if (k == 3) begin
                        m_cas = d;
                        m_id  = d[2:0];
                    end else begin
                        m_icw4 = d[4:0];
                    end
                    if (pending.size() == 0) begin
                        m_ready = 1;
                        if (!m_ic4) m_icw4[0] = UPM_DEF;
                    end
                end else if (m_ready) begin
                    m_o1 = 1'b1;
                end
            end else if (m_ready) begin
                m_o2 = !d[3];
                m_o3 = d[3];
            end
        end
    endtask

    task automatic check_all();
        logic exp_slave;
        logic exp_en_n;
        if (m_sngl) exp_slave = 1'b0;
        else if (m_icw4[3]) exp_slave = ~m_icw4[2];
        else exp_slave = ~sp_lvl;
        exp_en_n = m_icw4[3] ? ~dd_lvl : 1'b1;
        check("init_done", 32'(init_done), 32'(m_ready));
        check("ltim", 32'(level_or_edge_config), 32'(m_ltim));
        check("adi", 32'(call_address_interval_4), 32'(m_adi));
        check("sngl", 32'(single_mode), 32'(m_sngl));
        check("vector", 32'(vector_address), 32'(m_vec));
        check("cascade_cfg", 32'(cascade_config), 32'(m_cas));
        check("cascade_id", 32'(cascade_id), 32'(m_id));
        check("icw4", 32'({special_fully_nest_config,
                           buffered_mode_config,
                           buffered_master_or_slave_config,
                           auto_eoi_config,
                           u8086_or_mcs80_config}), 32'(m_icw4));
        check("slave_mode", 32'(slave_mode), 32'(exp_slave));
        check("en_oe", 32'(en_oe), 32'(m_icw4[3]));
        check("en_n_out", 32'(en_n_out), 32'(exp_en_n));
        check("ocw", 32'({write_ocw1, write_ocw2, write_ocw3}),
              32'({m_o1, m_o2, m_o3}));
    endtask

    task automatic step(input logic r, input logic ws,
                        input logic a0, input logic [7:0] d);
        @(negedge clock);
        reset             = r;
        write_strobe      = ws;
        address_a0        = a0;
        internal_data_bus = d;
        sp_en_n_in        = sp_lvl;
        drive_data_bus    = dd_lvl;
        @(posedge clock);
        #1;
        model(r, ws, a0, d);
        check_all();
    endtask

    task automatic wr(input logic a0, input logic [7:0] d);
        step(1'b0, 1'b1, a0, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int r;
        logic [7:0] d;
        reset = 1'b1; write_strobe = 1'b0; address_a0 = 1'b0;
        internal_data_bus = 8'h00; sp_en_n_in = 1'b1; drive_data_bus = 1'b0;

        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_ocw", 32'({write_ocw1, write_ocw2, write_ocw3}), 32'd0);

        // single, IC4=1
        wr(1'b0, 8'h13);
        wr(1'b1, 8'h20);
        check("tp1_mid", 32'(init_done), 32'd0);
        wr(1'b1, 8'h1F);
        check("tp1_done", 32'(init_done), 32'd1);
        check("tp1_vec", 32'(vector_address), 32'h100);
        check("tp1_sngl", 32'(single_mode), 32'd1);
        check("tp1_sfnm", 32'(special_fully_nest_config), 32'd1);
        check("tp1_upm", 32'(u8086_or_mcs80_config), 32'd1);
        check("tp1_slave", 32'(slave_mode), 32'd0);

        // cascade, buffered master
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h08);
        wr(1'b1, 8'h04);
        dd_lvl = 1'b1;
        wr(1'b1, 8'h0C);
        check("tp2_cas", 32'(cascade_config), 32'h04);
        check("tp2_buf", 32'(buffered_mode_config), 32'd1);
        check("tp2_slave", 32'(slave_mode), 32'd0);
        check("tp2_en_oe", 32'(en_oe), 32'd1);
        check("tp2_en_n", 32'(en_n_out), 32'd0);
        dd_lvl = 1'b0;
        idle();
        check("tp2_en_n_off", 32'(en_n_out), 32'd1);

        // cascade slave via pin, ICW4 skipped
        sp_lvl = 1'b0;
        wr(1'b0, 8'h10);
        wr(1'b1, 8'h40);
        wr(1'b1, 8'h02);
        check("tp3_done", 32'(init_done), 32'd1);
        check("tp3_id", 32'(cascade_id), 32'd2);
        check("tp3_slave", 32'(slave_mode), 32'd1);
        check("tp3_upm", 32'(u8086_or_mcs80_config), 32'(UPM_DEF));

        // OCW strobes
        wr(1'b1, 8'hFF);
        check("tp4_ocw1", 32'({write_ocw1, write_ocw2, write_ocw3}), 32'd4);
        wr(1'b0, 8'h20);
        check("tp4_ocw2", 32'({write_ocw1, write_ocw2, write_ocw3}), 32'd2);
        wr(1'b0, 8'h0B);
        check("tp4_ocw3", 32'({write_ocw1, write_ocw2, write_ocw3}), 32'd1);
        idle();
        check("tp4_quiet", 32'({write_ocw1, write_ocw2, write_ocw3}), 32'd0);
        check("tp4_done", 32'(init_done), 32'd1);

        // restart in WAIT_ICW3, then reset in WAIT_ICW4
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h08);
        wr(1'b0, 8'h11);
        check("tp5_done", 32'(init_done), 32'd0);
        check("tp5_upm", 32'(u8086_or_mcs80_config), 32'd0);
        wr(1'b1, 8'h08);
        wr(1'b1, 8'h04);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        wr(1'b1, 8'h1F);
        check("tp5_rst_done", 32'(init_done), 32'd0);
        check("tp5_rst_icw4", 32'(buffered_mode_config), 32'd0);
        wr(1'b0, 8'h20);
        check("tp5_idle_ocw", 32'(write_ocw2), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            d = 8'($urandom);
            sp_lvl = 1'($urandom);
            dd_lvl = 1'($urandom);
            if (r == 0) begin
                step(1'b1, 1'($urandom), 1'($urandom), d);
            end else if (r <= 2) begin
                wr(1'b0, d | 8'h10);
            end else if (r <= 9) begin
                wr(1'b1, d);
            end else if (r <= 12) begin
                wr(1'b0, d);
            end else begin
                step(1'b0, 1'b0, 1'($urandom), d);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/icw_init_sequencer.md
Name: icw_init_sequencer

Overview:
Clocked, parametrised successor to the ICW4 configuration latch for the 8259A control logic.
- Decodes the full ICW1 -> ICW2 -> [ICW3] -> [ICW4] initialisation sequence from CPU writes.
- Holds every initialisation field in registers, not latches.
- Resolves master/slave role and the SP/EN pin behaviour.
- After initialisation, issues one-cycle OCW1/OCW2/OCW3 strobes to the IMR, priority and EOI logic.

Parameters:
- CASCADE_LINES, 8, number of cascade IR lines covered by the ICW3 slave mask (1..8).
- ID_WIDTH, 3, width of the slave cascade ID taken from ICW3 (1..3).
- DEFAULT_UPM, 0, value loaded into u8086_or_mcs80_config when ICW1.IC4=0.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- write_strobe  in  1  one-cycle pulse marking a CPU write.
- address_a0  in  1  A0 of the write.
- internal_data_bus  in  8  write data.
- sp_en_n_in  in  1  SP/EN pin level, sampled in non-buffered mode (1 = master).
- drive_data_bus  in  1  high while the 8259A drives D[7:0].
- init_done  out  1  initialisation sequence complete.
- level_or_edge_config  out  1  ICW1.LTIM.
- call_address_interval_4  out  1  ICW1.ADI.
- single_mode  out  1  ICW1.SNGL.
- vector_address  out  11  {ICW2[7:0], ICW1[7:5]}.
- cascade_config  out  CASCADE_LINES  ICW3[CASCADE_LINES-1:0].
- cascade_id  out  ID_WIDTH  ICW3[ID_WIDTH-1:0].
- special_fully_nest_config  out  1  ICW4 bit 4.
- buffered_mode_config  out  1  ICW4 bit 3.
- buffered_master_or_slave_config  out  1  ICW4 bit 2.
- auto_eoi_config  out  1  ICW4 bit 1.
- u8086_or_mcs80_config  out  1  ICW4 bit 0.
- slave_mode  out  1  resolved role (1 = slave).
- en_n_out  out  1  buffer enable, active low.
- en_oe  out  1  SP/EN pin output enable.
- write_ocw1  out  1  one-cycle OCW1 strobe.
- write_ocw2  out  1  one-cycle OCW2 strobe.
- write_ocw3  out  1  one-cycle OCW3 strobe.

Behaviour:
Reset:
- State goes to IDLE.
- Every register output is 0; init_done=0; all OCW strobes=0.

Decode (only when write_strobe=1):
- ICW1 = a0=0 & d[4]=1.
- OCW2 = a0=0 & d[4:3]=00.
- OCW3 = a0=0 & d[4:3]=01.
- a0=1 write = next ICW in the sequence, or OCW1 when in READY.

ICW1 (any state, including mid-sequence):
- Restarts the sequence: state goes to WAIT_ICW2; init_done=0.
- Captures LTIM=d3, ADI=d2, SNGL=d1, IC4=d0, vector_address[2:0]=d[7:5].
- Clears all five ICW4 fields and cascade_config/cascade_id to 0.
- Emits no OCW strobe.

State transitions (a0=1 write required to advance; no write = state held):
- IDLE: a0=1 writes and OCW writes are ignored; only ICW1 advances.
- WAIT_ICW2: vector_address[10:3]=d. Next state: SNGL=0 -> WAIT_ICW3; else IC4=1 -> WAIT_ICW4; else READY.
- WAIT_ICW3: cascade_config=d[CASCADE_LINES-1:0]; cascade_id=d[ID_WIDTH-1:0]. Next state: IC4 ? WAIT_ICW4 : READY.
- WAIT_ICW4: ICW4 fields=d[4:0]. Next state: READY.
- READY: init_done=1.
  - a0=1 -> write_ocw1 pulse.
  - OCW2/OCW3 decodes -> the matching strobe.
  - Strobes are registered: high exactly the cycle after the write, for one cycle.
- Entering READY with IC4=0 loads u8086_or_mcs80_config=DEFAULT_UPM; all other ICW4 fields stay 0.
- OCW2/OCW3-pattern writes in WAIT_* states are ignored; state is unchanged.
- init_done rises in the cycle after the final ICW write.

Role and pin resolution (combinational from registers/inputs):
- single_mode=1 -> slave_mode=0.
- Otherwise buffered_mode_config=1 -> slave_mode=~buffered_master_or_slave_config.
- Otherwise slave_mode=~sp_en_n_in.
- en_oe=buffered_mode_config.
- en_n_out = buffered ? ~drive_data_bus : 1.

Priorities:
- reset > ICW1 > all other writes.
- A reset asserted mid-sequence aborts it; the next a0=1 write is then ignored.

Test Plan:
- Reset, then ICW1=0x13, ICW2=0x20, ICW4=0x1F -> READY after 3 writes; init_done=1 the cycle after ICW4; vector_address=0x100; single_mode=1; all ICW4 fields=1; slave_mode=0.
- ICW1=0x11, ICW2=0x08, ICW3=0x04, ICW4=0x0C -> cascade_config=0x04; buffered_mode_config=1; buffered_master_or_slave_config=1; slave_mode=0; en_oe=1; drive_data_bus=1 gives en_n_out=0.
- ICW1=0x10 (SNGL=0, IC4=0), ICW2=0x40, ICW3=0x02, sp_en_n_in=0 -> READY after ICW3; cascade_id=2; slave_mode=1; u8086_or_mcs80_config=DEFAULT_UPM; ICW4 path skipped.
- After init: a0=1 0xFF, a0=0 0x20, a0=0 0x0B -> write_ocw1, then write_ocw2, then write_ocw3, each a single-cycle pulse one cycle after its write; init_done stays 1.
- Mid-sequence ICW1 (in WAIT_ICW3) -> state returns to WAIT_ICW2; init_done=0; ICW4 fields=0. Reset asserted in WAIT_ICW4 -> all outputs 0; the following a0=1 write has no effect.
